// File: rtl/zx_mem_mapper_pkg.sv
// rtl/zx_mem_mapper_pkg.sv - shared decode constants, +3 bank table and I/O FSM states
package zx_mem_mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } io_state_e;

  localparam logic [3:0] P1FFD_A_HI   = 4'b0001;
  localparam int         P7_LOCK_BIT  = 5;
  localparam int         P7_ROM_BIT   = 4;
  localparam int         P7_SCR_BIT   = 3;
  localparam logic [2:0] FIXED_PAGE_1 = 3'd5;
  localparam logic [2:0] FIXED_PAGE_2 = 3'd2;

  // Rows list banks for regions 3..0 (MSB first), indexed by p1ffd[2:1].
  function automatic logic [2:0] special_bank(input logic [1:0] cfg, input logic [1:0] region);
    logic [11:0] row;
    int          idx;
    case (cfg)
      2'd0:    row = {3'd3, 3'd2, 3'd1, 3'd0};
      2'd1:    row = {3'd7, 3'd6, 3'd5, 3'd4};
      2'd2:    row = {3'd3, 3'd6, 3'd5, 3'd4};
      default: row = {3'd3, 3'd6, 3'd7, 3'd4};
    endcase
    idx = 3 * int'(region);
    return row[idx +: 3];
  endfunction

endpackage

// File: rtl/zx_sync2.sv
// rtl/zx_sync2.sv - two-flop synchroniser for active-low Z80 strobes, resets to idle (1)
module zx_sync2 (
  input  logic clock_25,
  input  logic RESET_N,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/zx_mem_mapper.sv
// rtl/zx_mem_mapper.sv - ZX Spectrum 128/+3 paging ports (7FFD/1FFD/FE) and memory address mapper
module zx_mem_mapper
  import zx_mem_mapper_pkg::*;
#(
  parameter int PAGE_BITS = 3,
  parameter bit PLUS3_EN  = 1'b0
) (
  input  logic                  clock_25,
  input  logic                  RESET_N,
  input  logic [15:0]           A,
  input  logic [7:0]            D,
  input  logic                  nIORQ,
  input  logic                  nMREQ,
  input  logic                  nRD,
  input  logic                  nWR,
  output logic [PAGE_BITS+13:0] ram_addr,
  output logic [15:0]           rom_addr,
  output logic                  rom_cs,
  output logic                  ram_we,
  output logic                  screen_page,
  output logic [2:0]            border,
  output logic                  beeper,
  output logic                  locked
);

  logic iorq_s;
  logic wr_s;

  zx_sync2 u_sync_iorq (.clock_25(clock_25), .RESET_N(RESET_N), .d_i(nIORQ), .q_o(iorq_s));
  zx_sync2 u_sync_wr   (.clock_25(clock_25), .RESET_N(RESET_N), .d_i(nWR),   .q_o(wr_s));

  io_state_e state_q, state_d;
  logic      commit;

  always_ff @(posedge clock_25) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Registers load on the edge that enters COMMIT, so one Z80 cycle yields one load.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!iorq_s && !wr_s) begin
          state_d = ST_COMMIT;
          commit  = 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_HOLD;
      ST_HOLD:   if (iorq_s || wr_s) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic       hit_1ffd, hit_7ffd, hit_fe;
  logic [7:0] p7ffd_q, p7ffd_d;
  logic [2:0] p1ffd_q, p1ffd_d;
  logic [2:0] border_q, border_d;
  logic       beeper_q, beeper_d;

  assign hit_1ffd = PLUS3_EN && (A[15:12] == P1FFD_A_HI) && !A[1];
  assign hit_7ffd = !A[15] && !A[1] && !hit_1ffd;
  assign hit_fe   = !A[0];

  always_comb begin
    p7ffd_d  = p7ffd_q;
    p1ffd_d  = p1ffd_q;
    border_d = border_q;
    beeper_d = beeper_q;
    if (commit) begin
      if (hit_1ffd && !locked) p1ffd_d = D[2:0];
      if (hit_7ffd && !locked) p7ffd_d = D;
      if (hit_fe) begin
        border_d = D[2:0];
        beeper_d = D[4];
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      p7ffd_q  <= '0;
      p1ffd_q  <= '0;
      border_q <= '0;
      beeper_q <= 1'b0;
    end else begin
      p7ffd_q  <= p7ffd_d;
      p1ffd_q  <= p1ffd_d;
      border_q <= border_d;
      beeper_q <= beeper_d;
    end
  end

  logic                 special;
  logic [1:0]           region;
  logic [4:0]           top_full;
  logic [PAGE_BITS-1:0] page;
  logic                 rom_region;

  assign special  = PLUS3_EN && p1ffd_q[0];
  assign region   = A[15:14];
  assign top_full = {p7ffd_q[6], p7ffd_q[7], p7ffd_q[2:0]};

  always_comb begin
    page       = '0;
    rom_region = 1'b0;
    if (special) begin
      page = PAGE_BITS'(special_bank(p1ffd_q[2:1], region));
    end else begin
      case (region)
        2'd0:    rom_region = 1'b1;
        2'd1:    page = PAGE_BITS'(FIXED_PAGE_1);
        2'd2:    page = PAGE_BITS'(FIXED_PAGE_2);
        default: page = top_full[PAGE_BITS-1:0];
      endcase
    end
  end

  assign ram_addr    = {page, A[13:0]};
  assign rom_addr    = {p1ffd_q[2] & PLUS3_EN, p7ffd_q[P7_ROM_BIT], A[13:0]};
  assign rom_cs      = !nMREQ && rom_region;
  assign ram_we      = !nMREQ && !nWR && !rom_region;
  assign screen_page = p7ffd_q[P7_SCR_BIT];
  assign border      = border_q;
  assign beeper      = beeper_q;
  assign locked      = p7ffd_q[P7_LOCK_BIT];

  // Read strobe and upper page bits are unused in narrower configurations.
  wire unused_ok = &{1'b0, nRD, top_full};

endmodule

// File: tb/tb_zx_mem_mapper.sv
// tb/tb_zx_mem_mapper.sv - scoreboard bench for zx_mem_mapper (512k, +3 paging)
module tb_zx_mem_mapper;

  localparam int PB = 5;

  logic            clock_25 = 1'b0;
  logic            RESET_N  = 1'b0;
  logic [15:0]     A        = '0;
  logic [7:0]      D        = '0;
  logic            nIORQ    = 1'b1;
  logic            nMREQ    = 1'b1;
  logic            nRD      = 1'b1;
  logic            nWR      = 1'b1;
  logic [PB+13:0]  ram_addr;
  logic [15:0]     rom_addr;
  logic            rom_cs, ram_we, screen_page, beeper, locked;
  logic [2:0]      border;

  zx_mem_mapper #(.PAGE_BITS(PB), .PLUS3_EN(1'b1)) dut (
    .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D),
    .nIORQ(nIORQ), .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR),
    .ram_addr(ram_addr), .rom_addr(rom_addr), .rom_cs(rom_cs), .ram_we(ram_we),
    .screen_page(screen_page), .border(border), .beeper(beeper), .locked(locked)
  );

  always #20 clock_25 = ~clock_25;

  int checks = 0;
  int errors = 0;

  logic [7:0] m7;
  logic [2:0] m1;
  logic [2:0] mb;
  logic       mbeep;

  typedef struct packed {
    logic [2:0] border;
    logic       beeper;
    logic       screen;
    logic       locked;
  } regs_t;

  typedef struct packed {
    logic [15:0]    a;
    logic           rom_cs;
    logic           ram_we;
    logic [PB+13:0] ram_addr;
    logic [15:0]    rom_addr;
  } mem_t;

  regs_t reg_q[$];
  mem_t  mem_q[$];

  function automatic regs_t model_regs();
    return {mb, mbeep, m7[3], m7[5]};
  endfunction

  function automatic regs_t obs_regs();
    return {border, beeper, screen_page, locked};
  endfunction

  function automatic mem_t obs_mem();
    mem_t m;
    m.a        = A;
    m.rom_cs   = rom_cs;
    m.ram_we   = ram_we;
    m.ram_addr = rom_cs ? '0 : ram_addr;
    m.rom_addr = rom_addr;
    return m;
  endfunction

  function automatic mem_t exp_mem(input logic [15:0] a, input logic wr);
    mem_t       m;
    logic [4:0] pg;
    logic       rom;
    rom = 1'b0;
    pg  = '0;
    if (m1[0]) begin
      case (m1[2:1])
        2'd0: pg = {3'b000, a[15:14]};
        2'd1: pg = 5'd4 + {3'b000, a[15:14]};
        2'd2: case (a[15:14]) 2'd0: pg = 5'd4; 2'd1: pg = 5'd5; 2'd2: pg = 5'd6; default: pg = 5'd3; endcase
        default: case (a[15:14]) 2'd0: pg = 5'd4; 2'd1: pg = 5'd7; 2'd2: pg = 5'd6; default: pg = 5'd3; endcase
      endcase
    end else begin
      case (a[15:14])
        2'd0: rom = 1'b1;
        2'd1: pg = 5'd5;
        2'd2: pg = 5'd2;
        default: pg = {m7[6], m7[7], m7[2:0]};
      endcase
    end
    m.a        = a;
    m.rom_cs   = rom;
    m.ram_we   = wr && !rom;
    m.ram_addr = rom ? '0 : {pg, a[13:0]};
    m.rom_addr = {m1[2], m7[4], a[13:0]};
    return m;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    logic lk;
    lk = m7[5];
    if (a[15:12] == 4'b0001 && !a[1]) begin
      if (!lk) m1 = d[2:0];
    end else if (!a[15] && !a[1]) begin
      if (!lk) m7 = d;
    end
    if (!a[0]) begin
      mb    = d[2:0];
      mbeep = d[4];
    end
  endtask

  task automatic do_reset();
    @(negedge clock_25);
    RESET_N = 1'b0; nIORQ = 1'b1; nWR = 1'b1; nMREQ = 1'b1;
    repeat (2) @(posedge clock_25);
    @(negedge clock_25);
    RESET_N = 1'b1;
    m7 = '0; m1 = '0; mb = '0; mbeep = 1'b0;
    reg_q.delete();
    mem_q.delete();
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock_25);
    nMREQ = 1'b1; A = a; D = d; nIORQ = 1'b0; nWR = 1'b0;
    model_write(a, d);
    reg_q.push_back(model_regs());
    repeat (4) @(posedge clock_25);
    @(negedge clock_25);
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (4) @(posedge clock_25);
    #1;
  endtask

  task automatic mem_drive(input logic [15:0] a, input logic wr);
    @(negedge clock_25);
    nIORQ = 1'b1; A = a; nMREQ = 1'b0; nWR = ~wr;
    mem_q.push_back(exp_mem(a, wr));
    #1;
  endtask

  task automatic mem_sweep(input string name, input logic [15:0] base, input logic wr);
    mem_t e;
    for (int r = 0; r < 4; r++) begin
      mem_drive(base + 16'(r * 16'h4000), wr);
      e = mem_q.pop_front();
      checks++;
      if (obs_mem() !== e) begin
        errors++;
        $display("FAIL %s region %0d: got %h expected %h", name, r, obs_mem(), e);
      end
    end
    @(negedge clock_25);
    nMREQ = 1'b1; nWR = 1'b1;
  endtask

  task automatic test_reset();
    regs_t e;
    do_reset();
    reg_q.push_back(model_regs());
    #1;
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL reset_regs: got %h expected %h", obs_regs(), e);
    end
    mem_sweep("reset_map", 16'h0123, 1'b1);
  endtask

  task automatic test_basic();
    regs_t e;
    io_write(16'h7FFD, 8'h17);
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL basic_regs: got %h expected %h", obs_regs(), e);
    end
    mem_drive(16'hC000, 1'b0);
    void'(mem_q.pop_front());
    checks++;
    if (ram_addr !== {5'd7, 14'h0000} || rom_addr !== 16'h4000 || screen_page !== 1'b0) begin
      errors++;
      $display("FAIL basic_c000: got ram %h rom %h scr %b expected 1c000 4000 0", ram_addr, rom_addr, screen_page);
    end
    mem_sweep("basic_map", 16'h0042, 1'b1);
  endtask

  task automatic test_latency();
    regs_t e;
    do_reset();
    @(negedge clock_25);
    A = 16'h00FE; D = 8'h05; nIORQ = 1'b0; nWR = 1'b0;
    model_write(16'h00FE, 8'h05);
    reg_q.push_back(model_regs());
    repeat (2) @(posedge clock_25);
    #1;
    checks++;
    if (border !== 3'd0) begin
      errors++;
      $display("FAIL latency_early: got %0d expected 0", border);
    end
    @(posedge clock_25);
    #1;
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL latency_third: got %h expected %h", obs_regs(), e);
    end
    D = 8'h02;
    repeat (9) @(posedge clock_25);
    #1;
    checks++;
    if (border !== 3'd5) begin
      errors++;
      $display("FAIL single_commit: got %0d expected 5", border);
    end
    @(negedge clock_25);
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (4) @(posedge clock_25);
  endtask

  task automatic test_lock();
    regs_t e;
    logic [15:0] wa[4] = '{16'h7FFD, 16'h7FFD, 16'h1FFD, 16'h00FE};
    logic [7:0]  wd[4] = '{8'h20, 8'h07, 8'h07, 8'h05};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      io_write(wa[i], wd[i]);
      e = reg_q.pop_front();
      checks++;
      if (obs_regs() !== e) begin
        errors++;
        $display("FAIL lock_step%0d: got %h expected %h", i, obs_regs(), e);
      end
    end
    checks++;
    if (locked !== 1'b1 || border !== 3'd5) begin
      errors++;
      $display("FAIL lock_const: got locked %b border %0d expected 1 5", locked, border);
    end
    mem_sweep("lock_map", 16'h0000, 1'b0);
  endtask

  task automatic test_combined();
    regs_t e;
    do_reset();
    io_write(16'h7FFC, 8'h1E);
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL combined_regs: got %h expected %h", obs_regs(), e);
    end
    mem_sweep("combined_map", 16'h3FFF, 1'b1);
  endtask

  task automatic test_page5();
    do_reset();
    io_write(16'h7FFD, 8'hC3);
    void'(reg_q.pop_front());
    mem_drive(16'hC123, 1'b0);
    void'(mem_q.pop_front());
    checks++;
    if (ram_addr !== {5'b11011, 14'h0123}) begin
      errors++;
      $display("FAIL page5_c123: got %h expected %h", ram_addr, {5'b11011, 14'h0123});
    end
    mem_sweep("page5_map", 16'h1111, 1'b0);
  endtask

  task automatic test_plus3();
    do_reset();
    io_write(16'h1FFD, 8'h07);
    void'(reg_q.pop_front());
    mem_drive(16'h0000, 1'b0);
    void'(mem_q.pop_front());
    checks++;
    if (rom_cs !== 1'b0 || ram_addr[18:14] !== 5'd4) begin
      errors++;
      $display("FAIL plus3_0000: got rom_cs %b page %0d expected 0 4", rom_cs, ram_addr[18:14]);
    end
    mem_drive(16'h4000, 1'b0);
    void'(mem_q.pop_front());
    checks++;
    if (ram_addr[18:14] !== 5'd7) begin
      errors++;
      $display("FAIL plus3_4000: got page %0d expected 7", ram_addr[18:14]);
    end
    for (int c = 0; c < 4; c++) begin
      io_write(16'h1FFD, 8'(c * 2 + 1));
      void'(reg_q.pop_front());
      mem_sweep($sformatf("plus3_cfg%0d", c), 16'h0777, 1'b1);
    end
    io_write(16'h1FFD, 8'h04);
    void'(reg_q.pop_front());
    io_write(16'h7FFD, 8'h10);
    void'(reg_q.pop_front());
    mem_sweep("plus3_rom3", 16'h2000, 1'b0);
  endtask

  task automatic test_reset_hold();
    regs_t e;
    do_reset();
    @(negedge clock_25);
    A = 16'h7FFD; D = 8'h38; nIORQ = 1'b0; nWR = 1'b0;
    model_write(16'h7FFD, 8'h38);
    reg_q.push_back(model_regs());
    repeat (4) @(posedge clock_25);
    #1;
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL hold_before: got %h expected %h", obs_regs(), e);
    end
    @(negedge clock_25);
    RESET_N = 1'b0;
    m7 = '0; m1 = '0; mb = '0; mbeep = 1'b0;
    reg_q.push_back(model_regs());
    @(posedge clock_25);
    #1;
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL hold_reset: got %h expected %h", obs_regs(), e);
    end
    @(negedge clock_25);
    RESET_N = 1'b1;
    repeat (2) @(posedge clock_25);
    #1;
    checks++;
    if (locked !== 1'b0 || screen_page !== 1'b0) begin
      errors++;
      $display("FAIL hold_early: got locked %b scr %b expected 0 0", locked, screen_page);
    end
    model_write(16'h7FFD, 8'h38);
    reg_q.push_back(model_regs());
    @(posedge clock_25);
    #1;
    e = reg_q.pop_front();
    checks++;
    if (obs_regs() !== e) begin
      errors++;
      $display("FAIL hold_reapply: got %h expected %h", obs_regs(), e);
    end
    @(negedge clock_25);
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (4) @(posedge clock_25);
  endtask

  initial begin
    m7 = '0; m1 = '0; mb = '0; mbeep = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_lock();
    test_combined();
    test_page5();
    test_plus3();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
